rv_cell_seq: RTL and testbench

Parametrised successor voter cell for the rootvoter: collects up to MAX_SETS redundant datasets under a configurable timeout, then votes with a sequential pairwise compare engine (one pair per cycle) instead of a fully parallel comparator array. It selects and outputs the majority value, reports per-set agreement counts, failure and timeout vectors, and a status code through a done/ack handshake. It sits between the dataset capture registers and the bus-side register file, one instance per voting channel.

---
 rtl/rv_seq_pkg.sv | 55 +++++
 rtl/rv_cell_seq_timer.sv | 39 +++
 rtl/rv_cell_seq.sv | 251 +++++++++++++++++++++++++
 tb/tb_rv_cell_seq.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_seq_pkg.sv
// rv_seq_pkg: shared types and helpers for
// the sequential successor voter cell.
package rv_seq_pkg;

  localparam int unsigned RV_SETS_MAX = 16;
  localparam int unsigned RV_IDX_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_VOTE,
    ST_SELECT,
    ST_RESULT
  } state_e;

  typedef enum logic [2:0] {
    RV_OK = 3'd0,
    RV_NO_MAJ = 3'd1,
    RV_TMO = 3'd2,
    RV_BAD_CFG = 3'd3
  } status_e;

  typedef struct packed {
    logic [RV_IDX_W-1:0] i;
    logic [RV_IDX_W-1:0] j;
  } pair_t;

  function automatic logic [RV_IDX_W-1:0] popcount(
    input logic [RV_SETS_MAX-1:0] v
  );
    logic [RV_IDX_W-1:0] c;
    c = '0;
    for (int k = 0; k < int'(RV_SETS_MAX); k++) begin
      c = c + {{(RV_IDX_W-1){1'b0}}, v[k]};
    end
    return c;
  endfunction

  // Row-major walk over i<j<n; j wraps to i+2.
  function automatic pair_t pair_next(
    input pair_t p,
    input logic [RV_IDX_W-1:0] n
  );
    pair_t r;
    if ((p.j + RV_IDX_W'(1)) < n) begin
      r.i = p.i;
      r.j = p.j + RV_IDX_W'(1);
    end else begin
      r.i = p.i + RV_IDX_W'(1);
      r.j = p.i + RV_IDX_W'(2);
    end
    return r;
  endfunction

endpackage

// File: rtl/rv_cell_seq_timer.sv
// rv_timer: loadable down-counter that flags
// the cycle in which it reaches zero.
module rv_timer #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load wins over counting; stop at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero load never fires, so 0 means no limit.
  assign expired_o = en_i && (cnt_q == W'(1));

endmodule

// File: rtl/rv_cell_seq.sv
// rv_cell_seq: redundant-set voter with a
// one-pair-per-cycle compare engine.
module rv_cell_seq
  import rv_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MAX_SETS = 16,
  parameter int unsigned TIMER_WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(MAX_SETS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_W-1:0]      cfg_used,
  input  logic [CNT_W-1:0]      cfg_min,
  input  logic [TIMER_WIDTH-1:0] cfg_timeout,
  input  logic                  abort,
  input  logic [MAX_SETS-1:0][DATA_WIDTH-1:0] sets,
  input  logic [MAX_SETS-1:0]   valid,
  input  logic                  ack,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] voted_value,
  output logic                  voted_ok,
  output logic [MAX_SETS-1:0][CNT_W-1:0] match_cnt,
  output logic [MAX_SETS-1:0]   fail_vec,
  output logic [MAX_SETS-1:0]   timeout_vec,
  output logic [2:0]            status,
  output logic                  busy
);

  localparam int unsigned IW =
    (MAX_SETS > 1) ? $clog2(MAX_SETS) : 1;
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_TWO = CNT_W'(2);
  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_SETS);
  localparam logic [CNT_W-1:0] C_SAT = CNT_W'(MAX_SETS - 1);

  state_e                state_q, state_d;
  status_e               status_q, status_d;
  logic [CNT_W-1:0]      used_q, used_d;
  logic [CNT_W-1:0]      min_q, min_d;
  logic [MAX_SETS-1:0]   part_q, part_d;
  pair_t                 pair_q, pair_d;
  logic [MAX_SETS-1:0][CNT_W-1:0] match_q, match_d;
  logic [MAX_SETS-1:0]   fail_q, fail_d;
  logic [MAX_SETS-1:0]   tvec_q, tvec_d;
  logic                  ok_q, ok_d;
  logic [DATA_WIDTH-1:0] value_q, value_d;

  logic                  cfg_ok;
  logic                  tmr_load;
  logic                  tmr_exp;
  logic [MAX_SETS-1:0]   used_mask;
  logic [MAX_SETS-1:0]   live;
  logic [RV_IDX_W-1:0]   live_cnt;
  logic [RV_IDX_W-1:0]   n5;
  logic [IW-1:0]         pi, pj;
  logic                  pair_hit;
  logic                  pair_last;
  logic                  sel_found;
  logic [CNT_W-1:0]      sel_best;
  logic [IW-1:0]         sel_win;
  logic [MAX_SETS-1:0]   sel_fail;
  logic                  sel_ok;

  assign cfg_ok = (cfg_used >= C_TWO)
               && (cfg_used <= C_MAX)
               && (cfg_min >= C_ONE)
               && (cfg_min <= cfg_used);

  assign tmr_load = (state_q == ST_IDLE)
                 && start && cfg_ok;

  rv_timer #(
    .W (TIMER_WIDTH)
  ) u_timer (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (tmr_load),
    .load_val_i (cfg_timeout),
    .en_i       (state_q == ST_WAIT),
    .expired_o  (tmr_exp)
  );

  // Sets 0..used-1 take part in this vote.
  always_comb begin
    used_mask = '0;
    for (int k = 0; k < int'(MAX_SETS); k++) begin
      used_mask[k] = (k < int'(used_q));
    end
  end

  assign live     = valid & used_mask;
  assign live_cnt = popcount(RV_SETS_MAX'(live));
  assign n5       = RV_IDX_W'(used_q);

  assign pi = IW'(pair_q.i);
  assign pj = IW'(pair_q.j);
  assign pair_hit = part_q[pi] && part_q[pj]
                 && (sets[pi] == sets[pj]);
  assign pair_last = (pair_q.i == n5 - RV_IDX_W'(2))
                  && (pair_q.j == n5 - RV_IDX_W'(1));

  // Winner: lowest participating index with top count.
  always_comb begin
    sel_found = 1'b0;
    sel_best  = '0;
    sel_win   = '0;
    sel_fail  = '0;
    for (int k = 0; k < int'(MAX_SETS); k++) begin
      if (part_q[k]
          && (!sel_found || (match_q[k] > sel_best))) begin
        sel_found = 1'b1;
        sel_best  = match_q[k];
        sel_win   = IW'(k);
      end
      sel_fail[k] = part_q[k]
                 && ((match_q[k] + C_ONE) < min_q);
    end
  end

  assign sel_ok = sel_found
               && ((sel_best + C_ONE) >= min_q);

  // Next-state and result datapath.
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    used_d   = used_q;
    min_d    = min_q;
    part_d   = part_q;
    pair_d   = pair_q;
    match_d  = match_q;
    fail_d   = fail_q;
    tvec_d   = tvec_q;
    ok_d     = ok_q;
    value_d  = value_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          status_d = cfg_ok ? RV_OK : RV_BAD_CFG;
          part_d   = '0;
          match_d  = '0;
          fail_d   = '0;
          tvec_d   = '0;
          ok_d     = 1'b0;
          value_d  = '0;
          pair_d   = '{i: '0, j: RV_IDX_W'(1)};
          if (cfg_ok) begin
            used_d  = cfg_used;
            min_d   = cfg_min;
            state_d = ST_WAIT;
          end else begin
            state_d = ST_RESULT;
          end
        end
      end
      ST_WAIT: begin
        if (live_cnt == n5) begin
          part_d  = live;
          state_d = ST_VOTE;
        end else if (tmr_exp) begin
          part_d = live;
          tvec_d = ~valid & used_mask;
          if (live_cnt >= RV_IDX_W'(min_q)) begin
            state_d = ST_VOTE;
          end else begin
            status_d = RV_TMO;
            state_d  = ST_RESULT;
          end
        end
      end
      ST_VOTE: begin
        if (pair_hit) begin
          if (match_d[pi] != C_SAT) begin
            match_d[pi] = match_d[pi] + C_ONE;
          end
          if (match_d[pj] != C_SAT) begin
            match_d[pj] = match_d[pj] + C_ONE;
          end
        end
        if (pair_last) begin
          state_d = ST_SELECT;
        end else begin
          pair_d = pair_next(pair_q, n5);
        end
      end
      ST_SELECT: begin
        ok_d     = sel_ok;
        value_d  = sel_ok ? sets[sel_win] : '0;
        status_d = sel_ok ? RV_OK : RV_NO_MAJ;
        fail_d   = sel_fail;
        state_d  = ST_RESULT;
      end
      ST_RESULT: begin
        if (ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d  = ST_IDLE;
      status_d = RV_OK;
      match_d  = '0;
      fail_d   = '0;
      tvec_d   = '0;
      ok_d     = 1'b0;
      value_d  = '0;
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      status_q <= RV_OK;
      used_q   <= '0;
      min_q    <= '0;
      part_q   <= '0;
      pair_q   <= '0;
      match_q  <= '0;
      fail_q   <= '0;
      tvec_q   <= '0;
      ok_q     <= 1'b0;
      value_q  <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      used_q   <= used_d;
      min_q    <= min_d;
      part_q   <= part_d;
      pair_q   <= pair_d;
      match_q  <= match_d;
      fail_q   <= fail_d;
      tvec_q   <= tvec_d;
      ok_q     <= ok_d;
      value_q  <= value_d;
    end
  end

  assign done        = (state_q == ST_RESULT);
  assign busy        = (state_q != ST_IDLE);
  assign voted_value = value_q;
  assign voted_ok    = ok_q;
  assign match_cnt   = match_q;
  assign fail_vec    = fail_q;
  assign timeout_vec = tvec_q;
  assign status      = status_q;

endmodule

// File: tb/tb_rv_cell_seq.sv
// tb_rv_cell_seq: scoreboard bench for the
// sequential voter cell.
module tb_rv_cell_seq;

  typedef struct packed {
    int          cyc;
    logic [63:0] val;
    logic        ok;
    logic [2:0]  st;
    logic [15:0][4:0] mc;
    logic [15:0] fv;
    logic [15:0] tv;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [4:0]        cfg_used;
  logic [4:0]        cfg_min;
  logic [31:0]       cfg_timeout;
  logic              abort;
  logic [15:0][63:0] sets;
  logic [15:0]       valid;
  logic              ack;
  logic              done;
  logic [63:0]       voted_value;
  logic              voted_ok;
  logic [15:0][4:0]  match_cnt;
  logic [15:0]       fail_vec;
  logic [15:0]       timeout_vec;
  logic [2:0]        status;
  logic              busy;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t q[$];
  int   arr[16];
  logic [63:0] dat[16];
  logic [63:0] pool[3];

  rv_cell_seq dut (
    .clk         (clk),
    .reset       (rst_n),
    .start       (start),
    .cfg_used    (cfg_used),
    .cfg_min     (cfg_min),
    .cfg_timeout (cfg_timeout),
    .abort       (abort),
    .sets        (sets),
    .valid       (valid),
    .ack         (ack),
    .done        (done),
    .voted_value (voted_value),
    .voted_ok    (voted_ok),
    .match_cnt   (match_cnt),
    .fail_vec    (fail_vec),
    .timeout_vec (timeout_vec),
    .status      (status),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, " done"}, 128'(done), 128'(0));
    chk({tag, " busy"}, 128'(busy), 128'(0));
    chk({tag, " status"}, 128'(status), 128'(0));
    chk({tag, " ok"}, 128'(voted_ok), 128'(0));
    chk({tag, " value"}, 128'(voted_value), 128'(0));
    chk({tag, " mcnt"}, 128'(match_cnt), 128'(0));
    chk({tag, " fvec"}, 128'(fail_vec), 128'(0));
    chk({tag, " tvec"}, 128'(timeout_vec), 128'(0));
  endtask

  // Reference: arrival edge arr[k] (0 = never),
  // latency in edges from the start-accept edge.
  function automatic exp_t model(input int n,
                                 input int m,
                                 input int t);
    exp_t e;
    int c, ex, np, cnt, best, win;
    logic [15:0] part;
    e = '0;
    if (n < 2 || n > 16 || m < 1 || m > n) begin
      e.st = 3'd3;
      return e;
    end
    c = 0;
    for (int k = 0; k < n; k++) begin
      if (arr[k] == 0) c = 1 << 20;
      else if (arr[k] > c) c = arr[k];
    end
    part = '0;
    if (t == 0 || c <= t) begin
      ex = c;
      for (int k = 0; k < n; k++) part[k] = 1'b1;
    end else begin
      ex = t;
      np = 0;
      for (int k = 0; k < n; k++) begin
        part[k] = (arr[k] != 0) && (arr[k] <= t);
        e.tv[k] = !part[k];
        if (part[k]) np++;
      end
      if (np < m) begin
        e.st = 3'd2;
        e.cyc = t;
        return e;
      end
    end
    for (int i = 0; i < n; i++) begin
      cnt = 0;
      for (int j = 0; j < n; j++) begin
        if (i != j && part[i] && part[j]
            && dat[i] == dat[j]) cnt++;
      end
      if (cnt > 15) cnt = 15;
      e.mc[i] = 5'(cnt);
    end
    best = -1;
    win = 0;
    for (int i = 0; i < n; i++) begin
      if (part[i] && int'(e.mc[i]) > best) begin
        best = int'(e.mc[i]);
        win = i;
      end
    end
    e.ok = (best + 1 >= m);
    e.val = e.ok ? dat[win] : 64'd0;
    e.st = e.ok ? 3'd0 : 3'd1;
    for (int i = 0; i < n; i++) begin
      e.fv[i] = part[i] && (int'(e.mc[i]) + 1 < m);
    end
    e.cyc = ex + n * (n - 1) / 2 + 1;
    return e;
  endfunction

  // Drive a start; optionally push the expectation.
  task automatic launch(input int n, input int m,
                        input int t, input bit pe,
                        input exp_t ein);
    exp_t e;
    e = ein;
    @(posedge clk);
    #1;
    for (int k = 0; k < 16; k++) begin
      sets[k] = dat[k];
      valid[k] = (arr[k] == 1);
    end
    cfg_used = 5'(n);
    cfg_min = 5'(m);
    cfg_timeout = 32'(t);
    start = 1'b1;
    e.cyc = e.cyc + cyc + 1;
    if (pe) q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int w;
    w = 0;
    while ((busy || done || q.size() != 0) && w < 600) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (w >= 600) begin
      bad++;
      total++;
      $display("FAIL %s: timeout busy=%0b q=%0d",
               nm, busy, q.size());
      q.delete();
    end
  endtask

  task automatic issue(input string nm, input int n,
                       input int m, input int t);
    exp_t e;
    e = model(n, m, t);
    launch(n, m, t, 1'b1, e);
    for (int d = 2; d <= 9; d++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 16; k++) begin
        if (arr[k] == d) valid[k] = 1'b1;
      end
    end
    wait_idle(nm);
    valid = '0;
  endtask

  // Monitor: compare each result against the queue.
  initial begin : monitor
    exp_t e;
    ack = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !ack) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected done status=%0d",
                   status);
        end else begin
          e = q.pop_front();
          chk("latency", 128'(cyc), 128'(e.cyc));
          chk("status", 128'(status), 128'(e.st));
          chk("voted_ok", 128'(voted_ok), 128'(e.ok));
          chk("voted_value", 128'(voted_value),
              128'(e.val));
          chk("match_cnt", 128'(match_cnt), 128'(e.mc));
          chk("fail_vec", 128'(fail_vec), 128'(e.fv));
          chk("timeout_vec", 128'(timeout_vec),
              128'(e.tv));
        end
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
      end
    end
  end

  task automatic clear_arr();
    for (int k = 0; k < 16; k++) begin
      arr[k] = 0;
      dat[k] = {$urandom, $urandom};
    end
  endtask

  initial begin : stim
    exp_t z;
    int n, m, t;
    z = '0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    valid = '0;
    sets = '0;
    cfg_used = '0;
    cfg_min = '0;
    cfg_timeout = '0;
    for (int k = 0; k < 3; k++) pool[k] = {$urandom, $urandom};
    pool[1][0] = ~pool[0][0];
    pool[2][1] = ~pool[0][1];
    pool[2][0] = pool[0][0];
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_idle_outs("post-reset");

    // {A,A,B} all valid with start.
    clear_arr();
    dat[0] = pool[0]; dat[1] = pool[0]; dat[2] = pool[1];
    for (int k = 0; k < 3; k++) arr[k] = 1;
    issue("aab", 3, 2, 0);

    // Sets 3,4 never arrive; expiry after 20.
    clear_arr();
    for (int k = 0; k < 3; k++) begin
      dat[k] = pool[2];
      arr[k] = 1;
    end
    dat[3] = pool[0]; dat[4] = pool[1];
    issue("expiry-vote", 5, 3, 20);

    // Too few arrivals at expiry.
    clear_arr();
    arr[0] = 1;
    issue("expiry-short", 4, 3, 10);

    // Bad configurations.
    clear_arr();
    arr[0] = 1;
    issue("bad-used1", 1, 1, 0);
    issue("bad-min", 4, 5, 0);
    issue("bad-min0", 4, 0, 0);
    issue("bad-used17", 17, 2, 0);

    // Tie {A,B,A,B}: lowest index wins.
    clear_arr();
    dat[0] = pool[0]; dat[1] = pool[1];
    dat[2] = pool[0]; dat[3] = pool[1];
    for (int k = 0; k < 4; k++) arr[k] = 1;
    issue("tie", 4, 2, 0);

    // Abort in VOTE: no done, then restart.
    clear_arr();
    for (int k = 0; k < 6; k++) begin
      dat[k] = pool[k % 2];
      arr[k] = 1;
    end
    launch(6, 2, 0, 1'b0, z);
    repeat (3) @(posedge clk);
    #1;
    chk("abort busy before", 128'(busy), 128'(1));
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort busy", 128'(busy), 128'(0));
    chk("abort done", 128'(done), 128'(0));
    repeat (20) @(posedge clk);
    #1;
    chk("abort done later", 128'(done), 128'(0));
    valid = '0;
    issue("after-abort", 6, 2, 0);

    // Reset asserted mid-VOTE.
    launch(6, 2, 0, 1'b0, z);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outs("mid-vote reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    valid = '0;
    @(posedge clk);
    #1;

    // Completion and expiry on the same edge.
    clear_arr();
    dat[0] = pool[1]; dat[1] = pool[0]; dat[2] = pool[1];
    arr[0] = 1; arr[1] = 2; arr[2] = 3;
    issue("complete-vs-expiry", 3, 2, 3);

    // Randomised runs.
    for (int r = 0; r < 30; r++) begin
      n = $urandom_range(2, 7);
      m = $urandom_range(1, n);
      t = ($urandom_range(0, 3) == 0) ? 0
                                      : $urandom_range(2, 14);
      if ($urandom_range(0, 9) == 0) m = n + 1;
      for (int k = 0; k < 16; k++) begin
        if (k < n) begin
          dat[k] = pool[$urandom_range(0, 2)];
          if (t != 0 && $urandom_range(0, 4) == 0)
            arr[k] = 0;
          else
            arr[k] = $urandom_range(1, 8);
        end else begin
          dat[k] = {$urandom, $urandom};
          arr[k] = $urandom_range(0, 3);
        end
      end
      issue("random", n, m, t);
    end

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
